regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of write requesters sharing the register file's single write port (legal 2..8).
REQ-002 SHALL have port Clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port ReqValid  input  NREQ  per-requester write request.
REQ-005 SHALL have port ReqAddr  input  5*NREQ  target register per requester; requester i in bits [5i+4:5i].
REQ-006 SHALL have port ReqData  input  32*NREQ  write data per requester; requester i in bits [32i+31:32i].
REQ-007 SHALL have port ReqReady  output  NREQ  grant; at most one bit high in any cycle.
REQ-008 SHALL have port RegWrite  output  1  write enable to the register file.
REQ-009 SHALL have port WriteRegister  output  5  write address to the register file.
REQ-010 SHALL have port WriteData  output  32  write data to the register file.
REQ-011 SHALL have port Busy  output  1  high while the arbiter is not accepting requests.

Function
REQ-012 SHALL implement states INIT and RUN; ReqReady SHALL be all-zero outside RUN.
REQ-013 SHALL complete a transfer for requester i on a rising edge where ReqValid[i] and ReqReady[i] are both high.
REQ-014 SHALL drive ReqReady combinationally in RUN: one-hot to the first valid requester at or after priority pointer P, searching upward modulo NREQ; all-zero when no request is valid.
REQ-015 SHALL set P to (i+1) mod NREQ after a transfer by requester i; SHALL hold P in cycles without a transfer.
REQ-016 SHALL register the accepted address and data onto WriteRegister/WriteData with RegWrite high in the cycle after acceptance (latency 1); the register file commits on the following edge.
REQ-017 SHALL accept writes with address 0 normally but hold RegWrite low for them (zero register never written).
REQ-018 SHALL hold RegWrite low in any RUN cycle following an edge with no transfer; WriteRegister/WriteData SHALL hold their last values.
REQ-019 SHALL sustain one transfer per cycle under continuous requests; with all NREQ valid, grants SHALL rotate 0,1,...,NREQ-1,0.
REQ-020 SHALL ignore ReqAddr/ReqData of non-granted requesters; a requester dropping ReqValid before grant SHALL be allowed.
REQ-021 SHALL drive Busy high exactly when the state is not RUN.

Reset
REQ-022 SHALL, on Reset high, immediately force RegWrite=0, WriteRegister=0, WriteData=0, ReqReady=0, P=0, sweep counter=0.
REQ-023 SHALL drop any accepted-but-not-issued write when Reset asserts mid-operation.
REQ-024 SHALL leave reset into INIT when sweep is compiled in, else into RUN, on the first rising edge after Reset deasserts.

Configuration
REQ-025 SHALL compile the init sweep in when macro REGFILE_WRITE_ARBITER_INIT_SWEEP_EN is defined.
REQ-026 SHALL, with the macro defined, in INIT issue RegWrite=1, WriteData=0, WriteRegister=1..31 on 31 consecutive cycles, then enter RUN; Busy high for those 31 cycles.
REQ-027 SHALL, without the macro, contain no INIT state or sweep counter; Busy SHALL be constant 0 after reset.

Structure
REQ-028 SHALL take REG_ADDR_W=5, DATA_W=32, NUM_REGS=32 and the state enum from shared package regarb_pkg.
REQ-029 SHALL place the round-robin search in one combinational sub-module rr_priority_select (inputs valid vector and pointer, output one-hot grant).

Verification
REQ-030 SHALL cover: single request, req1 valid addr=5 data=0xDEADBEEF -> ReqReady=0010 same cycle; next cycle RegWrite=1, WriteRegister=5, WriteData=0xDEADBEEF.
REQ-031 SHALL cover: all four valid for 8 cycles from P=0 -> grant order 0,1,2,3,0,1,2,3; RegWrite high 8 consecutive cycles.
REQ-032 SHALL cover: req2 valid addr=0 data=0x1234 -> accepted; next cycle RegWrite=0; P advances to 3.
REQ-033 SHALL cover: Reset pulsed the cycle after a grant -> RegWrite, WriteRegister, WriteData=0 immediately; write never issued; first post-reset grant goes to requester 0.
REQ-034 SHALL cover: with REGFILE_WRITE_ARBITER_INIT_SWEEP_EN, reset release with req0 valid -> 31 zero writes to regs 1..31, Busy high 31 cycles, ReqReady=0 throughout; req0 granted the first RUN cycle.

Source files
------------

// File: rtl/regarb_pkg.sv
// Shared widths and FSM state type for the register-file write arbiter.
// The INIT state only exists when REGFILE_WRITE_ARBITER_INIT_SWEEP_EN is defined.
package regarb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

`ifdef REGFILE_WRITE_ARBITER_INIT_SWEEP_EN
  localparam int SWEEP_CNT_W = $clog2(NUM_REGS);

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } arbState_t;
`endif

endpackage

// File: rtl/regfile_write_arbiter_rr_priority_select.sv
// Combinational round-robin search: one-hot grant to the first valid
// requester at or after ptr, wrapping modulo NREQ.
module rr_priority_select #(
  parameter int NREQ = 4,
  localparam int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  valid,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  grant
);

  always_comb begin
    // NOTE: default assigned first so no path leaves grant unassigned (no latch).
    grant = '0;
    // Walk from the farthest offset down so the nearest valid requester wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (valid[(int'(ptr) + k) % NREQ]) begin
        grant = '0;
        grant[(int'(ptr) + k) % NREQ] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register file's single write port, with a
// one-cycle registered write stage. Optional zeroing sweep of regs 1..31 after
// reset when REGFILE_WRITE_ARBITER_INIT_SWEEP_EN is defined.
module regfile_write_arbiter
  import regarb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic [NREQ-1:0]              ReqValid,
  input  logic [REG_ADDR_W*NREQ-1:0]   ReqAddr,
  input  logic [DATA_W*NREQ-1:0]       ReqData,
  output logic [NREQ-1:0]              ReqReady,
  output logic                         RegWrite,
  output logic [REG_ADDR_W-1:0]        WriteRegister,
  output logic [DATA_W-1:0]            WriteData,
  output logic                         Busy
);

  localparam int PTR_W = $clog2(NREQ);

  logic [PTR_W-1:0]      prioPtr;
  logic [PTR_W-1:0]      nextPtr;
  logic [PTR_W-1:0]      grantIdx;
  logic [NREQ-1:0]       rrGrant;
  logic                  inRun;
  logic                  transfer;
  logic                  sweepIssue;
  logic [REG_ADDR_W-1:0] sweepReg;
  logic [REG_ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0]     selData;

  rr_priority_select #(.NREQ(NREQ)) uSelect (
    .valid (ReqValid),
    .ptr   (prioPtr),
    .grant (rrGrant)
  );

  // Reset gates the grant combinationally so it drops the instant Reset rises.
  assign ReqReady = (inRun && !Reset) ? rrGrant : '0;
  assign transfer = |ReqReady;

  always_comb begin
    grantIdx = '0;
    selAddr  = '0;
    selData  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (ReqReady[i]) begin
        grantIdx = PTR_W'(i);
        selAddr  = ReqAddr[REG_ADDR_W*i +: REG_ADDR_W];
        selData  = ReqData[DATA_W*i +: DATA_W];
      end
    end
  end

  assign nextPtr = (grantIdx == PTR_W'(NREQ - 1)) ? '0 : grantIdx + 1'b1;

`ifdef REGFILE_WRITE_ARBITER_INIT_SWEEP_EN
  localparam logic [SWEEP_CNT_W-1:0] SWEEP_LAST = SWEEP_CNT_W'(NUM_REGS - 1);

  arbState_t             state;
  arbState_t             stateNext;
  logic [SWEEP_CNT_W-1:0] sweepCnt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= INIT;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (state == INIT && sweepCnt == SWEEP_LAST) stateNext = RUN;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)           sweepCnt <= '0;
    else if (sweepIssue) sweepCnt <= sweepCnt + 1'b1;
  end

  // sweepCnt counts writes already issued; the next one targets sweepCnt+1.
  assign sweepIssue = (state == INIT) && (sweepCnt != SWEEP_LAST);
  assign sweepReg   = REG_ADDR_W'(sweepCnt + 1'b1);
  assign inRun      = (state == RUN);
  assign Busy       = !inRun;
`else
  assign sweepIssue = 1'b0;
  assign sweepReg   = '0;
  assign inRun      = 1'b1;
  assign Busy       = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
      prioPtr       <= '0;
    end else if (sweepIssue) begin
      RegWrite      <= 1'b1;
      WriteRegister <= sweepReg;
      WriteData     <= '0;
    end else if (transfer) begin
      // Address 0 is accepted and consumes its turn but never reaches the file.
      RegWrite      <= (selAddr != '0);
      WriteRegister <= selAddr;
      WriteData     <= selData;
      prioPtr       <= nextPtr;
    end else begin
      RegWrite      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter (NREQ=4) with a
// reference round-robin model and a scoreboard of expected write-stage outputs.
module tb_regfile_write_arbiter;

  localparam int NREQ = 4;

  logic         Clk;
  logic         Reset;
  logic [3:0]   ReqValid;
  logic [19:0]  ReqAddr;
  logic [127:0] ReqData;
  logic [3:0]   ReqReady;
  logic         RegWrite;
  logic [4:0]   WriteRegister;
  logic [31:0]  WriteData;
  logic         Busy;

  regfile_write_arbiter #(.NREQ(NREQ)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .ReqValid      (ReqValid),
    .ReqAddr       (ReqAddr),
    .ReqData       (ReqData),
    .ReqReady      (ReqReady),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .Busy          (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        we;
    logic [4:0]  a;
    logic [31:0] d;
  } expWrite_t;

  expWrite_t   sb[$];
  int          checks = 0;
  int          errors = 0;
  int          mPtr   = 0;
  logic [4:0]  lastA  = '0;
  logic [31:0] lastD  = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] packA(input logic [4:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [127:0] packD(input logic [31:0] d0, d1, d2, d3);
    return {d3, d2, d1, d0};
  endfunction

  // Compare the write stage produced by the previous edge, if one is pending.
  task automatic popCompare();
    expWrite_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("RegWrite", 32'(RegWrite), 32'(e.we));
      check("WriteRegister", 32'(WriteRegister), 32'(e.a));
      check("WriteData", WriteData, e.d);
    end
  endtask

  // One clock cycle of stimulus: predict the grant, then push the expected write stage.
  task automatic step(input logic [3:0] v, input logic [19:0] a, input logic [127:0] d);
    logic [3:0] g;
    int         gi;
    int         idx;
    expWrite_t  e;
    @(negedge Clk);
    popCompare();
    ReqValid = v;
    ReqAddr  = a;
    ReqData  = d;
    #1;
    g  = '0;
    gi = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (mPtr + k) % NREQ;
      if (g == '0 && v[idx]) begin
        g[idx] = 1'b1;
        gi     = idx;
      end
    end
    check("ReqReady", 32'(ReqReady), 32'(g));
    check("Busy", 32'(Busy), 32'd0);
    if (g != '0) begin
      lastA = a[5*gi +: 5];
      lastD = d[32*gi +: 32];
      e.we  = (lastA != 5'd0);
      mPtr  = (gi + 1) % NREQ;
    end else begin
      e.we  = 1'b0;
    end
    e.a = lastA;
    e.d = lastD;
    sb.push_back(e);
  endtask

  // Release reset at a falling edge and walk to the first cycle that accepts requests.
  task automatic releaseReset();
`ifdef REGFILE_WRITE_ARBITER_INIT_SWEEP_EN
    ReqValid = 4'b0001;
    Reset    = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      @(negedge Clk);
      check("sweep_Busy", 32'(Busy), 32'd1);
      check("sweep_RegWrite", 32'(RegWrite), 32'd1);
      check("sweep_WriteRegister", 32'(WriteRegister), 32'(k));
      check("sweep_WriteData", WriteData, 32'd0);
      check("sweep_ReqReady", 32'(ReqReady), 32'd0);
    end
    @(negedge Clk);
    check("run_Busy", 32'(Busy), 32'd0);
    check("run_first_grant", 32'(ReqReady), 32'b0001);
    ReqValid = 4'b0000;
    lastA    = 5'd31;
    lastD    = '0;
    #1;
`else
    ReqValid = 4'b0000;
    Reset    = 1'b0;
    @(negedge Clk);
    check("run_Busy", 32'(Busy), 32'd0);
    check("idle_ReqReady", 32'(ReqReady), 32'd0);
`endif
  endtask

  logic [19:0]  addrAll;
  logic [127:0] dataAll;

  initial begin
    addrAll  = packA(5'd10, 5'd11, 5'd12, 5'd13);
    dataAll  = packD(32'hA0A0_0000, 32'hA1A1_1111, 32'hA2A2_2222, 32'hA3A3_3333);
    Reset    = 1'b1;
    ReqValid = 4'b1111;
    ReqAddr  = addrAll;
    ReqData  = dataAll;
    repeat (2) @(negedge Clk);

    check("rst_RegWrite", 32'(RegWrite), 32'd0);
    check("rst_WriteRegister", 32'(WriteRegister), 32'd0);
    check("rst_WriteData", WriteData, 32'd0);
    check("rst_ReqReady", 32'(ReqReady), 32'd0);
`ifdef REGFILE_WRITE_ARBITER_INIT_SWEEP_EN
    check("rst_Busy", 32'(Busy), 32'd1);
`else
    check("rst_Busy", 32'(Busy), 32'd0);
`endif

    releaseReset();

    // Single request from requester 1.
    step(4'b0010, packA(5'd0, 5'd5, 5'd0, 5'd0), packD(32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0));
    // Address-0 write from requester 2: accepted, never issued, pointer moves to 3.
    step(4'b0100, packA(5'd9, 5'd9, 5'd0, 5'd9), packD(32'h1, 32'h2, 32'h0000_1234, 32'h3));
    step(4'b1111, addrAll, dataAll);
    // All four valid from pointer 0: rotation 0,1,2,3,0,1,2,3.
    for (int k = 0; k < 8; k++) step(4'b1111, addrAll, dataAll);
    step(4'b0000, addrAll, dataAll);
    step(4'b1010, addrAll, dataAll);
    step(4'b0001, addrAll, dataAll);
    step(4'b0000, addrAll, dataAll);
    @(negedge Clk);
    popCompare();

    // Reset pulsed while an accepted write sits in the write stage.
    step(4'b0010, packA(5'd0, 5'd7, 5'd0, 5'd0), packD(32'h0, 32'hCAFE_F00D, 32'h0, 32'h0));
    @(posedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    check("rstmid_RegWrite", 32'(RegWrite), 32'd0);
    check("rstmid_WriteRegister", 32'(WriteRegister), 32'd0);
    check("rstmid_WriteData", WriteData, 32'd0);
    check("rstmid_ReqReady", 32'(ReqReady), 32'd0);
    sb.delete();
    mPtr  = 0;
    lastA = '0;
    lastD = '0;
    ReqValid = 4'b0000;
    @(negedge Clk);
    check("rstmid_hold_RegWrite", 32'(RegWrite), 32'd0);
    releaseReset();

    step(4'b1111, addrAll, dataAll);
    step(4'b0000, addrAll, dataAll);
    @(negedge Clk);
    popCompare();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
